// File: rtl/io_pkg.sv
// Shared defaults and types for the core I/O port responder.
package io_pkg;

  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned PORT_W_DEF     = 4;
  localparam int unsigned OUT_DEPTH_DEF  = 4;
  localparam int unsigned RD_TIMEOUT_DEF = 255;

  localparam logic [15:0] RD_ERR_WORD = 16'hFFFF;

  typedef enum logic {
    RD_IDLE,
    RD_WAIT
  } rd_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty flags.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_nxt;
  logic [AW:0]      rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push    = push & ~full;
    do_pop     = pop & ~empty;
    wr_ptr_nxt = wr_ptr + (AW+1)'(do_push);
    rd_ptr_nxt = rd_ptr + (AW+1)'(do_pop);
  end

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
      end
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    end
  end

  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/io_port_responder.sv
// Device-side responder for core OUTPUT/INPUT strobes: buffered transmit link,
// single-word receive register, stalled-read FSM with timeout, sticky error flags.
module io_port_responder
  import io_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned PORT_W     = PORT_W_DEF,
  parameter int unsigned OUT_DEPTH  = OUT_DEPTH_DEF,
  parameter int unsigned RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_strobe,
  input  logic              read_strobe,
  input  logic [PORT_W-1:0] port_id,
  input  logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] in_data,
  output logic              io_stall,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [PORT_W-1:0] tx_port,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rd_timeout,
  output logic              proto_err,
  input  logic              clr_err
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(RD_TIMEOUT);

  rd_state_t         rd_state;
  logic [15:0]       rd_count;
  logic [DATA_W-1:0] rx_buf;
  logic              rx_buf_valid;

  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_req;
  logic              rd_req;
  logic              both;
  logic              rd_hit;
  logic              rd_to;
  logic              rd_stall;

  // A cycle with both strobes high is a protocol error and acts on neither path.
  always_comb begin
    both     = write_strobe & read_strobe;
    wr_req   = write_strobe & ~read_strobe;
    rd_req   = read_strobe & ~write_strobe;
    rd_hit   = 1'b0;
    rd_to    = 1'b0;
    rd_stall = 1'b0;
    if (rd_req) begin
      if (rx_buf_valid) begin
        rd_hit = 1'b1;
      end else if (rd_state == RD_WAIT && rd_count >= TIMEOUT_LIMIT) begin
        rd_to = 1'b1;
      end else begin
        rd_stall = 1'b1;
      end
    end
  end

  io_sync_fifo #(
    .WIDTH (DATA_W + PORT_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_req),
    .din   ({port_id, out_data}),
    .pop   (tx_ready),
    .dout  ({tx_port, tx_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_valid = ~fifo_empty;
  assign rx_ready = ~rx_buf_valid;

  // Stall is gated by reset so a held strobe cannot keep the core frozen through reset.
  assign io_stall = rst_n & (rd_stall | (wr_req & fifo_full));

  always_comb begin
    in_data = '0;
    if (rd_hit) begin
      in_data = rx_buf;
    end else if (rd_to) begin
      in_data = DATA_W'(RD_ERR_WORD);
    end
  end

  // Any completed or dropped read returns to idle; otherwise keep waiting and counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_count <= '0;
    end else if (!rd_req || rd_hit || rd_to) begin
      rd_state <= RD_IDLE;
      rd_count <= '0;
    end else begin
      rd_state <= RD_WAIT;
      rd_count <= rd_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_buf       <= '0;
      rx_buf_valid <= 1'b0;
    end else if (rx_valid && !rx_buf_valid) begin
      rx_buf       <= rx_data;
      rx_buf_valid <= 1'b1;
    end else if (rd_hit) begin
      rx_buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_timeout <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (rd_to) begin
        rd_timeout <= 1'b1;
      end else if (clr_err) begin
        rd_timeout <= 1'b0;
      end
      if (both) begin
        proto_err <= 1'b1;
      end else if (clr_err) begin
        proto_err <= 1'b0;
      end
    end
  end

endmodule
